// File: rtl/rom_cache.sv
// Direct-mapped read-only cache between a CPU program-fetch port and the SDRAM ROM channel.
// Lookup takes two cycles: the tag/data RAMs are read in IDLE and compared in LOOKUP.
module rom_cache #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 9,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic              cache_valid,
  output logic [DATA_W-1:0] cache_data,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_valid,
  input  logic              flush,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_DONE} state_t;

  state_t r_state, w_next;

  logic [TAG_W-1:0]  r_tag_mem  [LINES];
  logic [DATA_W-1:0] r_data_mem [LINES];
  logic [TAG_W-1:0]  r_tag_q;
  logic [DATA_W-1:0] r_data_q;
  logic [LINES-1:0]  r_valid;
  logic              r_flush_pend;
  logic [ADDR_W-1:0] r_addr;

  logic [IDX_W-1:0]  w_idx_r;
  logic [TAG_W-1:0]  w_tag_r;
  logic              w_hit;
  logic              w_accept;
  logic              w_flush_now;
  logic              w_fill_done;
  logic              w_wr;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  assign w_idx_r     = r_addr[IDX_W-1:0];
  assign w_tag_r     = r_addr[ADDR_W-1:IDX_W];
  assign w_hit       = r_valid[w_idx_r] && (r_tag_q == w_tag_r);
  // A pending flush takes priority over a new request in IDLE.
  assign w_flush_now = (r_state == S_IDLE) && r_flush_pend;
  assign w_accept    = (r_state == S_IDLE) && !r_flush_pend && cache_req;
  assign w_fill_done = (r_state == S_FILL) && rom_valid && rom_req;
  assign w_wr        = w_fill_done && !reset;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: w_next = w_hit ? S_DONE : S_FILL;
      S_FILL:   if (w_fill_done) w_next = cache_req ? S_DONE : S_IDLE;
      S_DONE:   if (!cache_req) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Stage p0: capture address and read tag/data RAMs (datapath, not reset)
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_tag_mem[w_idx_r]  <= w_tag_r;
      r_data_mem[w_idx_r] <= rom_data;
    end
    if (w_accept) begin
      r_addr   <= cache_addr;
      r_tag_q  <= r_tag_mem[cache_addr[IDX_W-1:0]];
      r_data_q <= r_data_mem[cache_addr[IDX_W-1:0]];
    end
  end

  // Stage p1: hit decision, ROM fill and completion
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid  <= 1'b0;
      cache_data   <= '0;
      rom_req      <= 1'b0;
      rom_addr     <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      cache_valid  <= 1'b0;
      r_flush_pend <= flush | (r_flush_pend & !w_flush_now);
      if (w_flush_now) r_valid <= '0;
      if (r_state == S_LOOKUP) begin
        if (w_hit) begin
          cache_data  <= r_data_q;
          cache_valid <= 1'b1;
          hit_count   <= sat_inc(hit_count);
        end else begin
          rom_req    <= 1'b1;
          rom_addr   <= r_addr;
          miss_count <= sat_inc(miss_count);
        end
      end
      // An aborted fill still installs the line, it just does not complete.
      if (w_fill_done) begin
        rom_req          <= 1'b0;
        r_valid[w_idx_r] <= 1'b1;
        if (cache_req) begin
          cache_data  <= rom_data;
          cache_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_cache.sv
// Bench for rom_cache: a default instance and a small (8-bit data, 16-line, 2-bit stats) instance,
// both checked every cycle against an address-level cache model.
module tb_rom_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        req  [2];
  logic [18:0] addr [2];
  logic [31:0] rdat [2];
  logic        rvld [2];
  logic        fl   [2];

  logic        vld0, vld1, rr0, rr1;
  logic [31:0] cd0;
  logic [7:0]  cd1;
  logic [18:0] ra0, ra1;
  logic [15:0] hc0, mc0;
  logic [1:0]  hc1, mc1;

  rom_cache dut_a (
    .clk(clk), .reset(rst[0]), .cache_req(req[0]), .cache_addr(addr[0]),
    .cache_valid(vld0), .cache_data(cd0), .rom_req(rr0), .rom_addr(ra0),
    .rom_data(rdat[0]), .rom_valid(rvld[0]), .flush(fl[0]),
    .hit_count(hc0), .miss_count(mc0)
  );

  rom_cache #(.DATA_W(8), .IDX_W(4), .STAT_W(2)) dut_b (
    .clk(clk), .reset(rst[1]), .cache_req(req[1]), .cache_addr(addr[1]),
    .cache_valid(vld1), .cache_data(cd1), .rom_req(rr1), .rom_addr(ra1),
    .rom_data(rdat[1][7:0]), .rom_valid(rvld[1]), .flush(fl[1]),
    .hit_count(hc1), .miss_count(mc1)
  );

  // Address-level model: a line holds the full address it caches.
  logic [18:0] m_la [2][512];
  bit          m_lv [2][512];
  logic [31:0] m_ld [2][512];
  int          m_hits [2];
  int          m_miss [2];
  bit          m_ev [2];
  bit          m_rr [2];
  logic [31:0] m_ed [2];
  logic [18:0] m_ra [2];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset(input int k);
    m_hits[k] = 0;
    m_miss[k] = 0;
    m_ev[k]   = 1'b0;
    m_rr[k]   = 1'b0;
    for (int i = 0; i < 512; i++) m_lv[k][i] = 1'b0;
  endtask

  task automatic model_flush(input int k);
    for (int i = 0; i < 512; i++) m_lv[k][i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_a", 64'(vld0), 64'(m_ev[0]));
      if (m_ev[0]) check("data_a", 64'(cd0), 64'(m_ed[0]));
      check("romreq_a", 64'(rr0), 64'(m_rr[0]));
      if (m_rr[0]) check("romaddr_a", 64'(ra0), 64'(m_ra[0]));
      check("hits_a", 64'(hc0), 64'(m_hits[0]));
      check("miss_a", 64'(mc0), 64'(m_miss[0]));
      check("valid_b", 64'(vld1), 64'(m_ev[1]));
      if (m_ev[1]) check("data_b", 64'(cd1), 64'(m_ed[1][7:0]));
      check("romreq_b", 64'(rr1), 64'(m_rr[1]));
      if (m_rr[1]) check("romaddr_b", 64'(ra1), 64'(m_ra[1]));
      check("hits_b", 64'(hc1), 64'(m_hits[1]));
      check("miss_b", 64'(mc1), 64'(m_miss[1]));
    end
  end

  // One request: dly cycles from rom_req to rom_valid; abort drops req with rom_valid;
  // fl_fill pulses flush in the rom_valid cycle.
  task automatic txn(input int k, input logic [18:0] a, input int dly, input logic [31:0] w,
                     input bit abort, input bit fl_fill);
    int idx;
    int mx;
    bit hit;
    idx = int'(a) & ((k == 0) ? 32'h1FF : 32'hF);
    mx  = (k == 0) ? 65535 : 3;
    hit = m_lv[k][idx] && (m_la[k][idx] == a);
    @(posedge clk); #1;
    req[k]  = 1'b1;
    addr[k] = a;
    @(posedge clk);
    @(posedge clk); #1;
    if (hit) begin
      m_hits[k] = sat(m_hits[k], mx);
      m_ev[k]   = 1'b1;
      m_ed[k]   = m_ld[k][idx];
      req[k]    = 1'b0;
      @(posedge clk); #1;
      m_ev[k] = 1'b0;
    end else begin
      m_miss[k] = sat(m_miss[k], mx);
      m_rr[k]   = 1'b1;
      m_ra[k]   = a;
      repeat (dly) begin @(posedge clk); #1; end
      rvld[k] = 1'b1;
      rdat[k] = w;
      if (abort) req[k] = 1'b0;
      if (fl_fill) fl[k] = 1'b1;
      @(posedge clk); #1;
      rvld[k]      = 1'b0;
      fl[k]        = 1'b0;
      m_rr[k]      = 1'b0;
      m_lv[k][idx] = 1'b1;
      m_la[k][idx] = a;
      m_ld[k][idx] = w;
      if (fl_fill) model_flush(k);
      if (!abort) begin
        m_ev[k] = 1'b1;
        m_ed[k] = w;
        req[k]  = 1'b0;
        @(posedge clk); #1;
        m_ev[k] = 1'b0;
      end
    end
  endtask

  task automatic flush_pulse(input int k);
    @(posedge clk); #1;
    fl[k] = 1'b1;
    @(posedge clk); #1;
    fl[k] = 1'b0;
    model_flush(k);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; addr[k] = '0; rdat[k] = '0; rvld[k] = 1'b0; fl[k] = 1'b0;
      model_reset(k);
    end
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_hits_a", 64'(hc0), 64'd0);
    check("reset_miss_a", 64'(mc0), 64'd0);
    check("reset_data_a", 64'(cd0), 64'd0);
    check("reset_romreq_a", 64'(rr0), 64'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Cold miss, then hit
    txn(0, 19'h00123, 5, 32'hDEADBEEF, 1'b0, 1'b0);
    check("cold_miss_count", 64'(mc0), 64'd1);
    check("cold_data", 64'(cd0), 64'hDEADBEEF);
    check("cold_romaddr", 64'(ra0), 64'h00123);
    txn(0, 19'h00123, 0, 32'h0, 1'b0, 1'b0);
    check("hit_count_1", 64'(hc0), 64'd1);
    check("hit_data", 64'(cd0), 64'hDEADBEEF);

    // Conflict on index 0x123
    txn(0, 19'h00323, 2, 32'h11111111, 1'b0, 1'b0);
    txn(0, 19'h00123, 1, 32'hDEADBEEF, 1'b0, 1'b0);
    check("conflict_miss_count", 64'(mc0), 64'd3);

    // Flush invalidates a resident line
    flush_pulse(0);
    txn(0, 19'h00123, 3, 32'hDEADBEEF, 1'b0, 1'b0);
    check("flush_miss_count", 64'(mc0), 64'd4);

    // Stray rom_valid with no rom_req is ignored
    @(posedge clk); #1;
    rvld[0] = 1'b1;
    rdat[0] = 32'h55555555;
    @(posedge clk); #1;
    rvld[0] = 1'b0;

    // Abort still installs the line
    txn(0, 19'h00456, 2, 32'hCAFEF00D, 1'b1, 1'b0);
    txn(0, 19'h00456, 0, 32'h0, 1'b0, 1'b0);
    check("abort_hit_data", 64'(cd0), 64'hCAFEF00D);
    check("abort_hit_count", 64'(hc0), 64'd2);

    // Flush coincident with the fill write still invalidates that line
    txn(0, 19'h00789, 1, 32'h12345678, 1'b0, 1'b1);
    txn(0, 19'h00789, 1, 32'h12345678, 1'b0, 1'b0);
    check("flush_fill_miss_count", 64'(mc0), 64'd7);

    // Small instance: hit counter saturation
    txn(1, 19'h00005, 2, 32'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) txn(1, 19'h00005, 0, 32'h0, 1'b0, 1'b0);
    check("sat_hit_count", 64'(hc1), 64'd3);
    check("sat_data", 64'(cd1), 64'h3C);

    // Small instance: reset mid-fill, late rom_valid ignored
    @(posedge clk); #1;
    req[1]  = 1'b1;
    addr[1] = 19'h0000A;
    @(posedge clk);
    @(posedge clk); #1;
    m_miss[1] = sat(m_miss[1], 3);
    m_rr[1]   = 1'b1;
    m_ra[1]   = 19'h0000A;
    repeat (2) begin @(posedge clk); #1; end
    rst[1] = 1'b1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    model_reset(1);
    rst[1] = 1'b0;
    check("reset_fill_romreq", 64'(rr1), 64'd0);
    rvld[1] = 1'b1;
    rdat[1] = 32'h5A;
    @(posedge clk); #1;
    rvld[1] = 1'b0;
    @(posedge clk); #1;
    check("late_romvalid_no_valid", 64'(vld1), 64'd0);
    txn(1, 19'h0000A, 1, 32'h77, 1'b0, 1'b0);
    check("post_reset_miss_count", 64'(mc1), 64'd1);
    check("post_reset_data", 64'(cd1), 64'h77);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
